reg_bank_sb: RTL and testbench
==============================

Name: reg_bank_sb

Overview:
- Parametrised successor to the current register bank.
- Adds configurable width and depth, an asynchronous active-low reset, and registered dual read ports with write-to-read bypass.
- Adds a per-register scoreboard (busy bits) so the decode stage can detect RAW hazards against in-flight producers.
- Sits between decode (read/issue) and writeback (write/clear) in the pipelined datapath.

Parameters:
- N, 32, data width in bits.
- NREGS, 16, number of architectural registers; power of two, minimum 2.
- ADDR_W, $clog2(NREGS), register address width; derived, never overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en1  in  1  read port 1 enable.
- rd_addr1  in  ADDR_W  read port 1 register index.
- rd_data1  out  N  read port 1 data, registered.
- rd_busy1  out  1  read port 1 register has a pending producer, registered.
- rd_en2, rd_addr2, rd_data2, rd_busy2: identical to port 1.
- wr_en  in  1  writeback enable; also clears the busy bit of wr_addr.
- wr_addr  in  ADDR_W  writeback register index.
- wr_data  in  N  writeback data.
- iss_en  in  1  instruction issued with a destination register.
- iss_dest  in  ADDR_W  destination index to mark busy.
- any_busy  out  1  OR of all busy bits, registered; used for drain/flush.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = 0; all busy bits = 0.
  - rd_data1/2 = 0; rd_busy1/2 = 0; any_busy = 0.
  - State holds while rst_n is low. First update occurs on the first rising clk edge with rst_n high.
- Register 0 is hardwired:
  - reads always return 0 and busy 0.
  - writes to index 0 are ignored.
  - issues to index 0 never set a busy bit.
- Write: on a rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
- Read, per port, independently:
  - On a rising edge with rd_en=1, rd_data <= bypass value; result is visible 1 cycle after the request.
  - Bypass value = wr_data if (wr_en && wr_addr==rd_addr && rd_addr!=0), else reg[rd_addr] (0 for index 0).
  - rd_en=0: rd_data and rd_busy hold their previous values.
  - Both ports may read the same index in the same cycle.
- Busy status on a read:
  - rd_busy <= busy[rd_addr] & ~(wr_en && wr_addr==rd_addr).
  - A same-cycle writeback clears the hazard.
  - A same-cycle issue is not visible to a read in that cycle.
- Scoreboard update, per index i != 0, evaluated each edge:
  - busy[i] <= 1 if (iss_en && iss_dest==i).
  - Otherwise busy[i] <= 0 if (wr_en && wr_addr==i).
  - Otherwise busy[i] holds.
  - Issue wins over a same-cycle writeback to the same index: a new producer supersedes.
- Issue to an already-busy index: busy stays 1. No producer count is kept; the newest writeback clears it (in-order writeback contract).
- Writeback to a non-busy index: data is written and busy stays 0. This is not an error.
- any_busy <= OR of the next-state busy bits, so it goes low in the cycle the last busy bit clears.
- Reset mid-operation: all pending busy bits and in-flight read results are discarded immediately.
- No combinational path from any input to any output.

Decomposition:
- Shared package (reg_bank_pkg):
  - default N and NREGS.
  - the ADDR_W derivation function.
  - the constant ZERO_REG = 0.
- Sub-module reg_scoreboard: owns the NREGS busy bits, the set/clear priority, the per-port busy lookup with writeback masking, and any_busy. Parameter: NREGS.
- The data array and bypass muxes stay in reg_bank_sb.

Test Plan:
- Reset/zero register: assert rst_n=0 mid-run. Then write 0xDEADBEEF to r0 and read r0 on both ports → rd_data=0, rd_busy=0, all registers read 0 after reset.
- Basic write/read: write r5=0x12345678, then read r5 on the next cycle → rd_data1=0x12345678 one cycle after rd_en1.
- Bypass: in one cycle, write r7=0xA5A5A5A5 while rd_en1/rd_en2 read r7, with r7 previously 0x1 → both rd_data=0xA5A5A5A5 next cycle.
- Scoreboard set/clear:
  - Issue r3 at cycle t → read r3 at t+1 gives rd_busy1=1 and any_busy=1.
  - Writeback r3 at t+4 with a concurrent read → rd_busy1=0 and any_busy=0 after that edge.
- Simultaneous issue and writeback on r9 → busy[r9] remains 1. A read the following cycle returns rd_busy=1 and the newly written data.
- Hold and width: run N=64, NREGS=32. Write r31=0xFFFF_0000_FFFF_0000, then read it with rd_en high for one cycle and low for three → rd_data holds the value for all four cycles. Writing to r32 is impossible: ADDR_W=5 wraps to r0 and is ignored.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the scoreboarded register bank.
package reg_bank_pkg;

  localparam int DEF_N     = 32;
  localparam int DEF_NREGS = 16;
  localparam int ZERO_REG  = 0;

  function automatic int addr_w(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/reg_bank_sb_if.sv
// Decode/writeback-facing bus of the register bank: two read ports, writeback, issue.
interface reg_bank_sb_if
  import reg_bank_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int NREGS = DEF_NREGS
);

  localparam int ADDR_W = addr_w(NREGS);

  logic              rd_en1;
  logic [ADDR_W-1:0] rd_addr1;
  logic [N-1:0]      rd_data1;
  logic              rd_busy1;
  logic              rd_en2;
  logic [ADDR_W-1:0] rd_addr2;
  logic [N-1:0]      rd_data2;
  logic              rd_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-1:0]      wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_dest;
  logic              any_busy;

  modport master (
    output rd_en1, rd_addr1, rd_en2, rd_addr2,
    output wr_en, wr_addr, wr_data, iss_en, iss_dest,
    input  rd_data1, rd_busy1, rd_data2, rd_busy2, any_busy
  );

  modport slave (
    input  rd_en1, rd_addr1, rd_en2, rd_addr2,
    input  wr_en, wr_addr, wr_data, iss_en, iss_dest,
    output rd_data1, rd_busy1, rd_data2, rd_busy2, any_busy
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, issue wins on collision.
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter  int NREGS  = DEF_NREGS,
  localparam int ADDR_W = addr_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dest,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_en1,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic              rd_en2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  output logic              any_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    busy_nxt = busy;
    for (int i = 1; i < NREGS; i++) begin
      if (iss_en && iss_dest == ADDR_W'(i))
        busy_nxt[i] = 1'b1;
      else if (wr_en && wr_addr == ADDR_W'(i))
        busy_nxt[i] = 1'b0;
    end
    busy_nxt[ZERO_REG] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignment so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      any_busy <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      any_busy <= |busy_nxt;
    end
  end

  // Reads see the pre-edge busy state; a same-cycle writeback masks the hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_busy1 <= 1'b0;
      rd_busy2 <= 1'b0;
    end else begin
      if (rd_en1) rd_busy1 <= busy[rd_addr1] & ~(wr_en && wr_addr == rd_addr1);
      if (rd_en2) rd_busy2 <= busy[rd_addr2] & ~(wr_en && wr_addr == rd_addr2);
    end
  end

endmodule

// File: rtl/reg_bank_sb.sv
// Register bank with registered dual read ports, write-to-read bypass and RAW scoreboard.
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int NREGS = DEF_NREGS
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_bank_sb_if.slave  bus
);

  localparam int                ADDR_W = addr_w(NREGS);
  localparam logic [ADDR_W-1:0] R0     = ADDR_W'(ZERO_REG);

  logic [N-1:0] regs [NREGS];
  logic [N-1:0] byp1;
  logic [N-1:0] byp2;

  // regs[0] is never written, so it reads as zero without a special case.
  always_comb begin
    byp1 = regs[bus.rd_addr1];
    byp2 = regs[bus.rd_addr2];
    if (bus.wr_en && bus.wr_addr == bus.rd_addr1 && bus.rd_addr1 != R0) byp1 = bus.wr_data;
    if (bus.wr_en && bus.wr_addr == bus.rd_addr2 && bus.rd_addr2 != R0) byp2 = bus.wr_data;
  end

  // NOTE: the array is reset because architectural registers must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wr_en && bus.wr_addr != R0) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data1 <= '0;
      bus.rd_data2 <= '0;
    end else begin
      if (bus.rd_en1) bus.rd_data1 <= byp1;
      if (bus.rd_en2) bus.rd_data2 <= byp2;
    end
  end

  reg_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (bus.iss_en),
    .iss_dest (bus.iss_dest),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rd_en1   (bus.rd_en1),
    .rd_addr1 (bus.rd_addr1),
    .rd_en2   (bus.rd_en2),
    .rd_addr2 (bus.rd_addr2),
    .rd_busy1 (bus.rd_busy1),
    .rd_busy2 (bus.rd_busy2),
    .any_busy (bus.any_busy)
  );

endmodule

// File: tb/tb_reg_bank_sb.sv
// Self-checking bench: directed vector table, reset/r0 sequences, random run vs. model, 64x32 instance.
module tb_reg_bank_sb;
  import reg_bank_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  reg_bank_sb_if #(.N(32), .NREGS(16)) bus_a ();
  reg_bank_sb_if #(.N(64), .NREGS(32)) bus_b ();

  reg_bank_sb #(.N(32), .NREGS(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  reg_bank_sb #(.N(64), .NREGS(32)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic re1; logic [3:0] ra1; logic re2; logic [3:0] ra2;
    logic we;  logic [3:0] wa;  logic [31:0] wd;
    logic ie;  logic [3:0] id;
    logic [31:0] e_d1; logic e_b1; logic [31:0] e_d2; logic e_b2; logic e_any;
  } vec_t;

  vec_t vecs [19];

  // Behavioural view of DUT A: register contents, busy set, last read results.
  logic [31:0] m_regs [16];
  bit          m_busy [16];
  logic [31:0] e_d1, e_d2;
  logic        e_b1, e_b2, e_any;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.rd_en1 = 0; bus_a.rd_addr1 = 0; bus_a.rd_en2 = 0; bus_a.rd_addr2 = 0;
    bus_a.wr_en  = 0; bus_a.wr_addr  = 0; bus_a.wr_data = 0;
    bus_a.iss_en = 0; bus_a.iss_dest = 0;
  endtask

  task automatic idle_b();
    bus_b.rd_en1 = 0; bus_b.rd_addr1 = 0; bus_b.rd_en2 = 0; bus_b.rd_addr2 = 0;
    bus_b.wr_en  = 0; bus_b.wr_addr  = 0; bus_b.wr_data = 0;
    bus_b.iss_en = 0; bus_b.iss_dest = 0;
  endtask

  task automatic check_a(input string tag, input logic [31:0] d1, input logic b1,
                         input logic [31:0] d2, input logic b2, input logic any);
    check({tag, ".rd_data1"}, 64'(bus_a.rd_data1), 64'(d1));
    check({tag, ".rd_busy1"}, 64'(bus_a.rd_busy1), 64'(b1));
    check({tag, ".rd_data2"}, 64'(bus_a.rd_data2), 64'(d2));
    check({tag, ".rd_busy2"}, 64'(bus_a.rd_busy2), 64'(b2));
    check({tag, ".any_busy"}, 64'(bus_a.any_busy), 64'(any));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pat;
    logic [4:0]  a32;

    vecs[0]  = '{0,0,0,0, 1,5,32'h12345678, 0,0, 32'h0,0, 32'h0,0, 0};
    vecs[1]  = '{1,5,0,0, 0,0,32'h0,        0,0, 32'h12345678,0, 32'h0,0, 0};
    vecs[2]  = '{0,0,0,0, 1,7,32'h1,        0,0, 32'h12345678,0, 32'h0,0, 0};
    vecs[3]  = '{1,7,1,7, 1,7,32'hA5A5A5A5, 0,0, 32'hA5A5A5A5,0, 32'hA5A5A5A5,0, 0};
    vecs[4]  = '{0,0,0,0, 0,0,32'h0,        1,3, 32'hA5A5A5A5,0, 32'hA5A5A5A5,0, 1};
    vecs[5]  = '{1,3,0,0, 0,0,32'h0,        0,0, 32'h0,1, 32'hA5A5A5A5,0, 1};
    vecs[6]  = '{0,0,0,0, 0,0,32'h0,        0,0, 32'h0,1, 32'hA5A5A5A5,0, 1};
    vecs[7]  = '{0,0,0,0, 0,0,32'h0,        0,0, 32'h0,1, 32'hA5A5A5A5,0, 1};
    vecs[8]  = '{1,3,0,0, 1,3,32'h33,       0,0, 32'h33,0, 32'hA5A5A5A5,0, 0};
    vecs[9]  = '{0,0,0,0, 1,9,32'h99,       1,9, 32'h33,0, 32'hA5A5A5A5,0, 1};
    vecs[10] = '{0,0,1,9, 0,0,32'h0,        0,0, 32'h33,0, 32'h99,1, 1};
    vecs[11] = '{1,9,1,9, 1,9,32'h100,      0,0, 32'h100,0, 32'h100,0, 0};
    vecs[12] = '{1,0,1,0, 1,0,32'hDEADBEEF, 0,0, 32'h0,0, 32'h0,0, 0};
    vecs[13] = '{0,0,0,0, 0,0,32'h0,        1,0, 32'h0,0, 32'h0,0, 0};
    vecs[14] = '{1,0,0,0, 0,0,32'h0,        0,0, 32'h0,0, 32'h0,0, 0};
    vecs[15] = '{1,4,0,0, 0,0,32'h0,        1,4, 32'h0,0, 32'h0,0, 1};
    vecs[16] = '{1,4,0,0, 0,0,32'h0,        0,0, 32'h0,1, 32'h0,0, 1};
    vecs[17] = '{0,0,0,0, 1,4,32'h4,        0,0, 32'h0,1, 32'h0,0, 0};
    vecs[18] = '{1,4,0,0, 0,0,32'h0,        0,0, 32'h4,0, 32'h0,0, 0};

    idle_a();
    idle_b();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_a("reset", 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;

    // Directed table on the 32x16 instance.
    for (int i = 0; i < 19; i++) begin
      bus_a.rd_en1 = vecs[i].re1; bus_a.rd_addr1 = vecs[i].ra1;
      bus_a.rd_en2 = vecs[i].re2; bus_a.rd_addr2 = vecs[i].ra2;
      bus_a.wr_en  = vecs[i].we;  bus_a.wr_addr  = vecs[i].wa; bus_a.wr_data = vecs[i].wd;
      bus_a.iss_en = vecs[i].ie;  bus_a.iss_dest = vecs[i].id;
      step();
      check_a($sformatf("vec%0d", i), vecs[i].e_d1, vecs[i].e_b1,
              vecs[i].e_d2, vecs[i].e_b2, vecs[i].e_any);
    end

    // Mid-run reset with a pending producer and a live read result.
    idle_a();
    bus_a.iss_en = 1; bus_a.iss_dest = 6;
    bus_a.rd_en1 = 1; bus_a.rd_addr1 = 4;
    step();
    check_a("pre_rst", 32'h4, 0, 0, 0, 1);
    idle_a();
    #2 rst_n = 1'b0;
    #1;
    check_a("async_rst", 0, 0, 0, 0, 0);
    bus_a.wr_en = 1; bus_a.wr_addr = 5; bus_a.wr_data = 32'hFFFFFFFF;
    bus_a.rd_en1 = 1; bus_a.rd_addr1 = 5;
    step();
    check_a("rst_held", 0, 0, 0, 0, 0);
    idle_a();
    #2 rst_n = 1'b1;
    step();
    bus_a.wr_en = 1; bus_a.wr_addr = 0; bus_a.wr_data = 32'hDEADBEEF;
    bus_a.rd_en1 = 1; bus_a.rd_addr1 = 0; bus_a.rd_en2 = 1; bus_a.rd_addr2 = 0;
    step();
    check_a("r0_after_rst", 0, 0, 0, 0, 0);
    idle_a();
    bus_a.rd_en1 = 1; bus_a.rd_addr1 = 5; bus_a.rd_en2 = 1; bus_a.rd_addr2 = 6;
    step();
    check_a("regs_cleared", 0, 0, 0, 0, 0);

    // Random traffic against the behavioural model.
    for (int i = 0; i < 16; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    e_d1 = 0; e_d2 = 0; e_b1 = 0; e_b2 = 0; e_any = 0;
    for (int c = 0; c < 400; c++) begin
      logic re1, re2, we, ie;
      logic [3:0] ra1, ra2, wa, id;
      logic [31:0] wd;
      re1 = 1'($urandom_range(0, 1)); ra1 = 4'($urandom_range(0, 15));
      re2 = 1'($urandom_range(0, 1)); ra2 = 4'($urandom_range(0, 15));
      we  = 1'($urandom_range(0, 1)); wa  = 4'($urandom_range(0, 15));
      ie  = 1'($urandom_range(0, 1)); id  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      if ($urandom_range(0, 3) == 0) ra1 = wa;
      if ($urandom_range(0, 3) == 0) id  = wa;
      bus_a.rd_en1 = re1; bus_a.rd_addr1 = ra1; bus_a.rd_en2 = re2; bus_a.rd_addr2 = ra2;
      bus_a.wr_en  = we;  bus_a.wr_addr  = wa;  bus_a.wr_data = wd;
      bus_a.iss_en = ie;  bus_a.iss_dest = id;

      if (re1) begin
        e_d1 = (we && wa == ra1 && ra1 != 0) ? wd : m_regs[ra1];
        e_b1 = m_busy[ra1] && !(we && wa == ra1);
      end
      if (re2) begin
        e_d2 = (we && wa == ra2 && ra2 != 0) ? wd : m_regs[ra2];
        e_b2 = m_busy[ra2] && !(we && wa == ra2);
      end
      if (we && wa != 0) m_regs[wa] = wd;
      if (we) m_busy[wa] = 0;
      if (ie && id != 0) m_busy[id] = 1;
      e_any = 0;
      for (int r = 0; r < 16; r++) if (m_busy[r]) e_any = 1;

      step();
      check_a($sformatf("rand%0d", c), e_d1, e_b1, e_d2, e_b2, e_any);
    end
    idle_a();

    // Wide instance: read hold over three idle cycles, and address wrap onto r0.
    pat = 64'hFFFF_0000_FFFF_0000;
    bus_b.wr_en = 1; bus_b.wr_addr = 31; bus_b.wr_data = pat;
    step();
    bus_b.wr_en = 0;
    bus_b.rd_en1 = 1; bus_b.rd_addr1 = 31;
    step();
    check("b_read_r31", bus_b.rd_data1, pat);
    bus_b.rd_en1 = 0;
    bus_b.wr_en = 1; bus_b.wr_data = 64'h1234;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("b_hold%0d", k), bus_b.rd_data1, pat);
    end
    a32 = 5'(32);
    bus_b.wr_en = 1; bus_b.wr_addr = a32; bus_b.wr_data = '1;
    bus_b.rd_en1 = 1; bus_b.rd_addr1 = a32;
    step();
    check("b_wrap_bypass", bus_b.rd_data1, 64'h0);
    bus_b.wr_en = 0;
    step();
    check("b_wrap_r0", bus_b.rd_data1, 64'h0);
    bus_b.rd_en1 = 0;
    bus_b.iss_en = 1; bus_b.iss_dest = 31;
    step();
    bus_b.iss_en = 0;
    bus_b.rd_en1 = 1; bus_b.rd_addr1 = 31;
    step();
    check("b_busy_r31", 64'(bus_b.rd_busy1), 64'h1);
    check("b_any_busy", 64'(bus_b.any_busy), 64'h1);
    check("b_data_r31", bus_b.rd_data1, 64'h1234);
    idle_b();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
